alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the combinational SPARC integer ALU. Accepts one SPARC op3 operation per cycle through a valid/ready handshake. Holds the integer condition codes (icc: N, Z, V, C) and the Y register internally, and adds an iterative multi-cycle multiplier for UMUL/SMUL(cc). Sits in the execute stage between the operand muxes and the writeback register.

## Interface
- WIDTH, 32: operand/result width; ≥ 8, power of two.
- SHW, $clog2(WIDTH): shift-amount width; derived, do not override.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present on op3/a/b.
- in_ready  out  1  block can accept an operation this cycle.
- op3  in  6  SPARC op3 code.
- a  in  WIDTH  operand A (rs1).
- b  in  WIDTH  operand B (rs2 or simm).
- out_valid  out  1  one-cycle pulse: result/illegal valid.
- result  out  WIDTH  registered result.
- illegal  out  1  op3 not implemented; qualified by out_valid.
- icc_n, icc_z, icc_v, icc_c  out  1 each  registered condition codes.
- y  out  WIDTH  Y register (high half of last product).

## Operation
- Accept when in_valid && in_ready.
- ADDX/SUBX(cc) use the internal icc_c as carry-in; there is no external carry input.
- Single-cycle ops, with op3 codes identical to the existing ALU:
  - ADD/ADDcc/ADDX/ADDXcc, SUB/SUBcc/SUBX/SUBXcc.
  - AND/ANDN/OR/ORN/XOR/XNOR and their cc forms.
  - SLL 100101, SRL 100110, SRA 100111; shift by b[SHW-1:0].
- Multi-cycle ops: UMUL 001010, SMUL 001011, UMULcc 011010, SMULcc 011011.
  - 2·WIDTH-bit product; low half → result, high half → y.
- icc update: only cc variants, only on the out_valid cycle.
  - N = result[WIDTH-1]; Z = (result == 0).
  - Add: C = carry out of bit WIDTH-1; V = signed overflow.
  - Sub: C = borrow; V = (a[MSB] ≠ b[MSB]) && (a[MSB] ≠ result[MSB]).
  - Logic, shifts, MULcc: V = C = 0.
- Non-cc ops and illegal ops leave icc unchanged.
- Illegal op3: out_valid = 1, illegal = 1, result = 0; icc and y unchanged.
- Arithmetic is modulo 2^WIDTH. Carry/borrow is computed on WIDTH+1 bits.
- FSM states:
  - IDLE: in_ready = 1. Single-cycle op → result registered, stay IDLE. MUL op → latch operands, cnt = WIDTH-1, go MUL.
  - MUL: in_ready = 0. Each cycle: one shift-add step on magnitudes, cnt decrements. At cnt = 0 go DONE.
  - DONE: in_ready = 0. Apply sign correction (SMUL: negate the 2·WIDTH product if a[MSB] ^ b[MSB]). Register result/y/icc, pulse out_valid, go IDLE.

## Timing
- Reset values: result = 0, y = 0, all icc = 0, out_valid = 0, illegal = 0, in_ready = 1, state IDLE.
- Single-cycle op latency: accepted at edge k, out_valid high after edge k+1. Throughput is one per cycle back-to-back.
- A cc op immediately followed by an X op sees the icc_c updated by the first op (forwarded internally).
- MUL latency: WIDTH+1 cycles from acceptance to out_valid.
  - in_ready drops the cycle after acceptance.
  - in_ready returns high in the cycle out_valid is asserted, so a new op may be accepted that same cycle.
- in_valid while in_ready = 0: ignored, not queued.
- No output backpressure: out_valid is a single-cycle pulse; downstream must capture it.
- reset during MUL: operation aborted, no out_valid, all state and outputs return to reset values next cycle.
- result/icc/y hold their values between out_valid pulses.

## Configuration
- ALU_SEQ_MUL_EN defined: multiplier, MUL/DONE states and Y writes are compiled in.
- ALU_SEQ_MUL_EN undefined:
  - Multiplier logic and MUL/DONE states are absent.
  - MUL op3 codes are treated as illegal: 1-cycle out_valid with illegal = 1.
  - y stays 0 permanently; in_ready is tied high.

## Test plan
- ADDcc a = 0x7FFFFFFF, b = 1 → one cycle later result = 0x80000000, N = 1, Z = 0, V = 1, C = 0.
- SUBcc a = 5, b = 5, then SUBXcc a = 0, b = 0 on the next cycle → first: Z = 1, C = 0; second: result = 0, Z = 1.
- ADDcc 0xFFFFFFFF+1 (C = 1) followed back-to-back by ADDX 1+1 → result 3. Then SRA a = 0xA0000000, b = 4 → 0xFA000000, icc unchanged.
- SMULcc a = 0xFFFFFFFD (−3), b = 7 (mul enabled) → in_ready low for 32 cycles, out_valid at cycle 33, result = 0xFFFFFFEB, y = 0xFFFFFFFF, N = 1, V = C = 0.
- Assert reset at cycle 10 of a UMUL → no out_valid, result = y = 0, icc = 0, in_ready = 1 on the following cycle.
- op3 = 110101 → out_valid with illegal = 1, result 0, icc held. Without ALU_SEQ_MUL_EN, UMUL → illegal = 1 after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// Registered SPARC integer ALU with internal icc/Y and an iterative shift-add multiplier.
// The multiplier (MUL/DONE states, Y writes) is compiled in only when ALU_SEQ_MUL_EN is defined.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       op3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             illegal,
  output logic             icc_n,
  output logic             icc_z,
  output logic             icc_v,
  output logic             icc_c,
  output logic [WIDTH-1:0] y
);

  // Handshake: an op is taken on a rising edge where in_valid && in_ready; in_valid
  // while in_ready is low is dropped. out_valid is a one-cycle pulse with no backpressure.

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_cin;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_legal;
  logic             w_cc;
  logic             w_v;
  logic             w_c;
  logic             w_is_mul;

  logic             r_out_valid;
  logic             r_illegal;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_y;
  logic             r_icc_n;
  logic             r_icc_z;
  logic             r_icc_v;
  logic             r_icc_c;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_cnt;
  logic               r_neg;
  logic               r_mul_cc;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fin;

  // One shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   mc);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : {(WIDTH+1){1'b0}});
    return {sum, acc[WIDTH-1:1]};
  endfunction

  assign w_abs_a    = (op3[0] && a[MSB]) ? -a : a;
  assign w_abs_b    = (op3[0] && b[MSB]) ? -b : b;
  assign w_prod     = mul_step(r_acc, r_mcand);
  assign w_prod_fin = r_neg ? -w_prod : w_prod;
`endif

  assign w_accept = in_valid && w_in_ready;

  // X variants (op3[3] set) take the registered carry, already updated by a preceding cc op.
  assign w_cin = op3[3] ? r_icc_c : 1'b0;
  assign w_add = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_res    = '0;
    w_legal  = 1'b1;
    w_cc     = op3[4];
    w_v      = 1'b0;
    w_c      = 1'b0;
    w_is_mul = 1'b0;
    case (op3[5:4])
      2'b00, 2'b01: begin
        case (op3[3:0])
          4'b0000, 4'b1000: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
          end
          4'b0100, 4'b1100: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = (a[MSB] != b[MSB]) && (a[MSB] != w_sub[MSB]);
          end
          4'b0001: w_res = a & b;
          4'b0010: w_res = a | b;
          4'b0011: w_res = a ^ b;
          4'b0101: w_res = a & ~b;
          4'b0110: w_res = a | ~b;
          4'b0111: w_res = ~(a ^ b);
`ifdef ALU_SEQ_MUL_EN
          4'b1010, 4'b1011: w_is_mul = 1'b1;
`endif
          default: begin
            w_legal = 1'b0;
            w_cc    = 1'b0;
          end
        endcase
      end
      2'b10: begin
        w_cc = 1'b0;
        case (op3)
          6'b100101: w_res = a << b[SHW-1:0];
          6'b100110: w_res = a >> b[SHW-1:0];
          6'b100111: w_res = WIDTH'($signed(a) >>> b[SHW-1:0]);
          default:   w_legal = 1'b0;
        endcase
      end
      default: begin
        w_legal = 1'b0;
        w_cc    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // MUL leaves when the last counted step is taken (cnt 1 -> 0); DONE performs the final step.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
`ifdef ALU_SEQ_MUL_EN
      S_IDLE:  if (w_accept && w_is_mul) w_next_state = S_MUL;
      S_MUL:   if (r_cnt == SHW'(1)) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
`endif
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
`ifdef ALU_SEQ_MUL_EN
    w_in_ready = (r_state == S_IDLE);
`else
    w_in_ready = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_result    <= '0;
      r_y         <= '0;
      r_icc_n     <= 1'b0;
      r_icc_z     <= 1'b0;
      r_icc_v     <= 1'b0;
      r_icc_c     <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_mcand     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_mul_cc    <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == S_IDLE && w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_illegal   <= !w_legal;
        r_result    <= w_legal ? w_res : '0;
        if (w_legal && w_cc) begin
          r_icc_n <= w_res[MSB];
          r_icc_z <= (w_res == '0);
          r_icc_v <= w_v;
          r_icc_c <= w_c;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      if (r_state == S_IDLE && w_accept && w_is_mul) begin
        r_mcand  <= w_abs_a;
        r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
        r_cnt    <= SHW'(WIDTH - 1);
        r_neg    <= op3[0] && (a[MSB] ^ b[MSB]);
        r_mul_cc <= op3[4];
      end
      if (r_state == S_MUL) begin
        r_acc <= mul_step(r_acc, r_mcand);
        r_cnt <= r_cnt - SHW'(1);
      end
      if (r_state == S_DONE) begin
        r_out_valid <= 1'b1;
        r_illegal   <= 1'b0;
        r_result    <= w_prod_fin[WIDTH-1:0];
        r_y         <= w_prod_fin[2*WIDTH-1:WIDTH];
        if (r_mul_cc) begin
          r_icc_n <= w_prod_fin[MSB];
          r_icc_z <= (w_prod_fin[WIDTH-1:0] == '0);
          r_icc_v <= 1'b0;
          r_icc_c <= 1'b0;
        end
      end
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign illegal   = r_illegal;
  assign result    = r_result;
  assign icc_n     = r_icc_n;
  assign icc_z     = r_icc_z;
  assign icc_v     = r_icc_v;
  assign icc_c     = r_icc_c;
`ifdef ALU_SEQ_MUL_EN
  assign y = r_y;
`else
  assign y = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: reset, add/sub flags, carry chaining, logic/shift table,
// illegal op3 and the multiplier (or its illegal fallback without ALU_SEQ_MUL_EN).
module tb_alu_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [5:0]   op3 = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] result;
  logic         illegal;
  logic         icc_n, icc_z, icc_v, icc_c;
  logic [W-1:0] y;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_nzvc;

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] av;
    logic [W-1:0] bv;
    logic [W-1:0] res;
    logic         cc;
    logic [3:0]   nzvc;
  } vec_t;

  vec_t vecs [11] = '{
    '{6'b000001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 4'b0000},
    '{6'b000110, 32'h0000_00FF, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0, 4'b0000},
    '{6'b010111, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 4'b1000},
    '{6'b100101, 32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0, 4'b0000},
    '{6'b100110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 4'b0000},
    '{6'b010100, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 4'b1001},
    '{6'b010101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'b0100},
    '{6'b000011, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1'b0, 4'b0000},
    '{6'b010100, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 4'b0010},
    '{6'b010000, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 4'b0111},
    '{6'b001100, 32'h0000_0005, 32'h0000_0002, 32'h0000_0002, 1'b0, 4'b0000}
  };

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op3(op3), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .illegal(illegal), .icc_n(icc_n), .icc_z(icc_z), .icc_v(icc_v),
    .icc_c(icc_c), .y(y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic send(input logic [5:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = 1'b1;
    op3 = op;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h want 0", y); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0000) begin errors++; $display("FAIL reset_icc got %b want 0000", {icc_n, icc_z, icc_v, icc_c}); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addcc_overflow();
    send(6'b010000, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addcc_valid got %b want 1", out_valid); end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL addcc_result got %h want 80000000", result); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b1010) begin errors++; $display("FAIL addcc_icc got %b want 1010", {icc_n, icc_z, icc_v, icc_c}); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", out_valid); end
    checks++; if (result !== 32'h8000_0000) begin errors++; $display("FAIL idle_hold got %h want 80000000", result); end
  endtask

  task automatic test_sub_subx();
    send(6'b010100, 32'd5, 32'd5);
    checks++; if (result !== '0) begin errors++; $display("FAIL subcc_result got %h want 0", result); end
    checks++; if ({icc_z, icc_c} !== 2'b10) begin errors++; $display("FAIL subcc_zc got %b want 10", {icc_z, icc_c}); end
    send(6'b011100, 32'd0, 32'd0);
    checks++; if (result !== '0) begin errors++; $display("FAIL subxcc_result got %h want 0", result); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0100) begin errors++; $display("FAIL subxcc_icc got %b want 0100", {icc_n, icc_z, icc_v, icc_c}); end
  endtask

  task automatic test_back_to_back();
    send(6'b010000, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0101) begin errors++; $display("FAIL b2b_addcc_icc got %b want 0101", {icc_n, icc_z, icc_v, icc_c}); end
    send(6'b001000, 32'd1, 32'd1);
    checks++; if (result !== 32'd3) begin errors++; $display("FAIL b2b_addx_result got %h want 3", result); end
    send(6'b100111, 32'hA000_0000, 32'd4);
    checks++; if (result !== 32'hFA00_0000) begin errors++; $display("FAIL sra_result got %h want fa000000", result); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0101) begin errors++; $display("FAIL sra_icc got %b want 0101", {icc_n, icc_z, icc_v, icc_c}); end
  endtask

  task automatic test_logic_table();
    do_reset();
    exp_nzvc = 4'b0000;
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].op, vecs[i].av, vecs[i].bv);
      if (vecs[i].cc) exp_nzvc = vecs[i].nzvc;
      checks++; if (out_valid !== 1'b1 || illegal !== 1'b0) begin errors++; $display("FAIL vec%0d_valid got %b%b want 10", i, out_valid, illegal); end
      checks++; if (result !== vecs[i].res) begin errors++; $display("FAIL vec%0d_result got %h want %h", i, result, vecs[i].res); end
      checks++; if ({icc_n, icc_z, icc_v, icc_c} !== exp_nzvc) begin errors++; $display("FAIL vec%0d_icc got %b want %b", i, {icc_n, icc_z, icc_v, icc_c}, exp_nzvc); end
    end
  endtask

  task automatic test_illegal();
    send(6'b110101, 32'h0000_1234, 32'h0000_5678);
    checks++; if ({out_valid, illegal} !== 2'b11) begin errors++; $display("FAIL illegal_flags got %b%b want 11", out_valid, illegal); end
    checks++; if (result !== '0) begin errors++; $display("FAIL illegal_result got %h want 0", result); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0111) begin errors++; $display("FAIL illegal_icc got %b want 0111", {icc_n, icc_z, icc_v, icc_c}); end
    send(6'b000000, 32'd1, 32'd2);
    checks++; if (illegal !== 1'b0 || result !== 32'd3) begin errors++; $display("FAIL post_illegal got %b/%h want 0/3", illegal, result); end
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul();
    int n;
    logic ov_seen;
    send(6'b011011, 32'hFFFF_FFFD, 32'd7);
    n = 0;
    ov_seen = 1'b0;
    while (!in_ready && n < 40) begin
      if (out_valid) ov_seen = 1'b1;
      if (n >= 2 && n < 6) begin
        in_valid = 1'b1; op3 = 6'b000000; a = 32'd1; b = 32'd1;
      end else begin
        in_valid = 1'b0;
      end
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (n != 32) begin errors++; $display("FAIL smul_busy_cycles got %0d want 32", n); end
    checks++; if (ov_seen !== 1'b0) begin errors++; $display("FAIL smul_early_valid got %b want 0", ov_seen); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL smul_valid got %b want 1", out_valid); end
    checks++; if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL smul_result got %h want ffffffeb", result); end
    checks++; if (y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL smul_y got %h want ffffffff", y); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b1000) begin errors++; $display("FAIL smul_icc got %b want 1000", {icc_n, icc_z, icc_v, icc_c}); end
    send(6'b000000, 32'd10, 32'd20);
    checks++; if (out_valid !== 1'b1 || result !== 32'd30) begin errors++; $display("FAIL after_mul_add got %b/%h want 1/1e", out_valid, result); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_queue got %b want 0", out_valid); end
    send(6'b001010, 32'hFFFF_FFFF, 32'd2);
    n = 0;
    while (!out_valid && n < 40) begin n++; @(posedge clk); #1; end
    checks++; if (result !== 32'hFFFF_FFFE || y !== 32'd1) begin errors++; $display("FAIL umul got %h:%h want 00000001:fffffffe", y, result); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b1000) begin errors++; $display("FAIL umul_icc got %b want 1000", {icc_n, icc_z, icc_v, icc_c}); end
    send(6'b001010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_hs got %b%b want 01", out_valid, in_ready); end
    checks++; if (result !== '0 || y !== '0) begin errors++; $display("FAIL abort_data got %h:%h want 0:0", y, result); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0000) begin errors++; $display("FAIL abort_icc got %b want 0000", {icc_n, icc_z, icc_v, icc_c}); end
    ov_seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) ov_seen = 1'b1; end
    checks++; if (ov_seen !== 1'b0) begin errors++; $display("FAIL abort_late_valid got %b want 0", ov_seen); end
  endtask
`else
  task automatic test_mul();
    send(6'b001010, 32'd3, 32'd4);
    checks++; if ({out_valid, illegal} !== 2'b11) begin errors++; $display("FAIL umul_off_flags got %b%b want 11", out_valid, illegal); end
    checks++; if (result !== '0 || y !== '0) begin errors++; $display("FAIL umul_off_data got %h:%h want 0:0", y, result); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL umul_off_ready got %b want 1", in_ready); end
    send(6'b011011, 32'hFFFF_FFFD, 32'd7);
    checks++; if (illegal !== 1'b1 || y !== '0) begin errors++; $display("FAIL smulcc_off got %b/%h want 1/0", illegal, y); end
    checks++; if ({icc_n, icc_z, icc_v, icc_c} !== 4'b0111) begin errors++; $display("FAIL smulcc_off_icc got %b want 0111", {icc_n, icc_z, icc_v, icc_c}); end
  endtask
`endif

  initial begin
    test_reset();
    test_addcc_overflow();
    test_sub_subx();
    test_back_to_back();
    test_logic_table();
    test_illegal();
    test_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
